// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter that shares one AXI-stream write port among p_num_req producers.
// Each grant lasts at most p_max_burst beats; the data path is a pure AND-OR mux.

module fifo_rr_arbiter_lane #(
  parameter int p_width = 8
) (
  input  logic               i_sel,
  input  logic               i_valid,
  input  logic               i_ready_out,
  input  logic [p_width-1:0] i_data,
  output logic               o_grant,
  output logic               o_ready,
  output logic               o_valid,
  output logic [p_width-1:0] o_data
);
  assign o_grant = i_sel;
  assign o_ready = i_sel & i_ready_out;
  assign o_valid = i_sel & i_valid;
  assign o_data  = i_sel ? i_data : '0;
endmodule

module fifo_rr_arbiter #(
  parameter int p_width     = 8,
  parameter int p_num_req   = 4,
  parameter int p_max_burst = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [p_num_req*p_width-1:0] i_data_in,
  input  logic [p_num_req-1:0]         i_valid_in,
  output logic [p_num_req-1:0]         o_ready_in,
  output logic [p_width-1:0]           o_data_out,
  output logic                         o_valid_out,
  input  logic                         i_ready_out,
  output logic [p_num_req-1:0]         o_grant
);
  localparam int IDX_W = $clog2(p_num_req);
  localparam int CNT_W = $clog2(p_max_burst + 1);

  typedef enum logic {s_idle, s_grant} state_t;

  state_t                            state, state_d;
  logic [IDX_W-1:0]                  r_sel, r_last, sel_d, last_d, pick;
  logic [CNT_W-1:0]                  r_count, count_d;
  logic                              pick_vld, hs;
  logic [p_num_req-1:0][p_width-1:0] data_arr, lane_data;
  logic [p_num_req-1:0]              lane_sel, lane_valid;

  assign data_arr = i_data_in;

  // Rotating-priority search starting just after the last granted requester.
  always_comb begin : rr_search
    int               idx;
    logic [IDX_W-1:0] cand;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    cand     = '0;
    for (int i = 1; i <= p_num_req; i++) begin
      idx = int'(r_last) + i;
      if (idx >= p_num_req) idx = idx - p_num_req;
      cand = IDX_W'(idx);
      if (!pick_vld && i_valid_in[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < p_num_req; k++) begin : g_lane
      assign lane_sel[k] = (state == s_grant) && (r_sel == IDX_W'(k));
      fifo_rr_arbiter_lane #(.p_width(p_width)) u_lane (
        .i_sel       (lane_sel[k]),
        .i_valid     (i_valid_in[k]),
        .i_ready_out (i_ready_out),
        .i_data      (data_arr[k]),
        .o_grant     (o_grant[k]),
        .o_ready     (o_ready_in[k]),
        .o_valid     (lane_valid[k]),
        .o_data      (lane_data[k])
      );
    end
  endgenerate

  // At most one lane is selected, so OR-reduction acts as the output mux.
  always_comb begin
    o_data_out  = '0;
    o_valid_out = 1'b0;
    for (int i = 0; i < p_num_req; i++) begin
      o_data_out  = o_data_out | lane_data[i];
      o_valid_out = o_valid_out | lane_valid[i];
    end
  end

  assign hs = o_valid_out & i_ready_out;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= s_idle;
      r_sel   <= '0;
      r_last  <= IDX_W'(p_num_req - 1);
      r_count <= '0;
    end else begin
      state   <= state_d;
      r_sel   <= sel_d;
      r_last  <= last_d;
      r_count <= count_d;
    end
  end

  // Release on the final beat of a burst, or when the owner goes quiet without
  // a handshake; a stalled FIFO with valid held keeps the grant.
  always_comb begin
    state_d = state;
    sel_d   = r_sel;
    last_d  = r_last;
    count_d = r_count;
    case (state)
      s_idle: begin
        if (pick_vld) begin
          state_d = s_grant;
          sel_d   = pick;
          count_d = '0;
        end
      end
      s_grant: begin
        if (hs) begin
          count_d = r_count + CNT_W'(1);
          if (r_count == CNT_W'(p_max_burst - 1)) begin
            state_d = s_idle;
            last_d  = r_sel;
          end
        end else if (!i_valid_in[r_sel]) begin
          state_d = s_idle;
          last_d  = r_sel;
        end
      end
      default: state_d = s_idle;
    endcase
  end
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: reset, bursts, rotation, backpressure, early release.

module tb_fifo_rr_arbiter;
  localparam int W = 8;
  localparam int N = 4;
  localparam int B = 4;

  logic           i_clk = 1'b0;
  logic           i_reset_n = 1'b0;
  logic [N*W-1:0] i_data_in = '0;
  logic [N-1:0]   i_valid_in = '0;
  logic [N-1:0]   o_ready_in;
  logic [W-1:0]   o_data_out;
  logic           o_valid_out;
  logic           i_ready_out = 1'b0;
  logic [N-1:0]   o_grant;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  fifo_rr_arbiter #(.p_width(W), .p_num_req(N), .p_max_burst(B)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_data_in   (i_data_in),
    .i_valid_in  (i_valid_in),
    .o_ready_in  (o_ready_in),
    .o_data_out  (o_data_out),
    .o_valid_out (o_valid_out),
    .i_ready_out (i_ready_out),
    .o_grant     (o_grant)
  );

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset;
    i_valid_in  = '0;
    i_ready_out = 1'b0;
    i_data_in   = '0;
    i_reset_n   = 1'b0;
    tick();
    tick();
    i_reset_n   = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    i_data_in   = '1;
    i_valid_in  = '1;
    i_ready_out = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (o_grant !== 4'b0001) begin
      n_err++; $display("FAIL reset_pre_grant got %b exp %b", o_grant, 4'b0001);
    end
    i_reset_n = 1'b0;
    #1;
    n_cmp++;
    if (o_grant !== 4'b0000) begin
      n_err++; $display("FAIL reset_async_grant got %b exp %b", o_grant, 4'b0000);
    end
    n_cmp++;
    if (o_valid_out !== 1'b0) begin
      n_err++; $display("FAIL reset_async_valid got %b exp %b", o_valid_out, 1'b0);
    end
    n_cmp++;
    if (o_ready_in !== 4'b0000) begin
      n_err++; $display("FAIL reset_async_ready got %b exp %b", o_ready_in, 4'b0000);
    end
    n_cmp++;
    if (o_data_out !== 8'h00) begin
      n_err++; $display("FAIL reset_async_data got %h exp %h", o_data_out, 8'h00);
    end
    #1;
    i_reset_n = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (o_grant !== 4'b0001) begin
      n_err++; $display("FAIL reset_first_grant got %b exp %b", o_grant, 4'b0001);
    end
    n_cmp++;
    if (o_data_out !== 8'hFF) begin
      n_err++; $display("FAIL reset_first_data got %h exp %h", o_data_out, 8'hFF);
    end
  endtask

  task automatic test_single;
    logic [3:0] eg [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010};
    logic [7:0] ed [7] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h14, 8'h15};
    int beat;
    beat = 0;
    do_reset();
    i_ready_out     = 1'b1;
    i_valid_in      = 4'b0010;
    i_data_in[15:8] = 8'h10;
    tick();
    for (int c = 0; c < 7; c++) begin
      i_data_in[15:8] = 8'(8'h10 + beat);
      i_valid_in[1]   = (beat < 6);
      #1;
      n_cmp++;
      if (o_grant !== eg[c]) begin
        n_err++; $display("FAIL single_grant cyc=%0d got %b exp %b", c + 1, o_grant, eg[c]);
      end
      n_cmp++;
      if (o_data_out !== ed[c]) begin
        n_err++; $display("FAIL single_data cyc=%0d got %h exp %h", c + 1, o_data_out, ed[c]);
      end
      n_cmp++;
      if (o_ready_in !== eg[c]) begin
        n_err++; $display("FAIL single_ready cyc=%0d got %b exp %b", c + 1, o_ready_in, eg[c]);
      end
      if (eg[c] != 4'b0000) beat++;
      tick();
    end
  endtask

  task automatic test_all_four;
    int beats [N];
    int hs_cnt;
    int g;
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    hs_cnt = 0;
    for (int k = 0; k < N; k++) beats[k] = 0;
    do_reset();
    i_ready_out = 1'b1;
    i_valid_in  = 4'b1111;
    tick();
    for (int c = 1; c <= 21; c++) begin
      for (int k = 0; k < N; k++) i_data_in[k*W +: W] = 8'(k*16 + beats[k]);
      #1;
      g     = ((c - 1) / 5) % 4;
      exp_g = (((c - 1) % 5) == 4) ? 4'b0000 : 4'(1 << g);
      n_cmp++;
      if (o_grant !== exp_g) begin
        n_err++; $display("FAIL all4_grant cyc=%0d got %b exp %b", c, o_grant, exp_g);
      end
      if (exp_g != 4'b0000) begin
        exp_d = 8'(g*16 + beats[g]);
        n_cmp++;
        if (o_data_out !== exp_d) begin
          n_err++; $display("FAIL all4_data cyc=%0d got %h exp %h", c, o_data_out, exp_d);
        end
        beats[g]++;
      end
      if (c <= 20 && o_valid_out && i_ready_out) hs_cnt++;
      tick();
    end
    n_cmp++;
    if (hs_cnt !== 16) begin
      n_err++; $display("FAIL all4_beats got %0d exp %0d", hs_cnt, 16);
    end
  endtask

  task automatic test_backpressure;
    int beat;
    logic [3:0] exp_g;
    logic [3:0] exp_r;
    beat = 0;
    do_reset();
    i_ready_out = 1'b1;
    i_valid_in  = 4'b1111;
    i_data_in[7:0] = 8'hA0;
    tick();
    for (int c = 1; c <= 9; c++) begin
      i_ready_out    = !(c >= 3 && c <= 5);
      i_data_in[7:0] = 8'(8'hA0 + beat);
      #1;
      exp_g = (c <= 7) ? 4'b0001 : ((c == 8) ? 4'b0000 : 4'b0010);
      exp_r = i_ready_out ? exp_g : 4'b0000;
      n_cmp++;
      if (o_grant !== exp_g) begin
        n_err++; $display("FAIL bp_grant cyc=%0d got %b exp %b", c, o_grant, exp_g);
      end
      n_cmp++;
      if (o_ready_in !== exp_r) begin
        n_err++; $display("FAIL bp_ready cyc=%0d got %b exp %b", c, o_ready_in, exp_r);
      end
      if (c <= 7) begin
        n_cmp++;
        if (o_data_out !== 8'(8'hA0 + beat)) begin
          n_err++; $display("FAIL bp_data cyc=%0d got %h exp %h", c, o_data_out, 8'(8'hA0 + beat));
        end
        if (i_ready_out) beat++;
      end
      tick();
    end
  endtask

  task automatic test_early_release;
    do_reset();
    i_ready_out = 1'b1;
    i_valid_in  = 4'b1100;
    i_data_in[23:16] = 8'h20;
    i_data_in[31:24] = 8'h30;
    tick();
    for (int c = 1; c <= 2; c++) begin
      i_data_in[23:16] = 8'(8'h20 + c - 1);
      #1;
      n_cmp++;
      if (o_grant !== 4'b0100 || o_data_out !== 8'(8'h20 + c - 1)) begin
        n_err++; $display("FAIL early_burst cyc=%0d got %b/%h exp %b/%h",
                          c, o_grant, o_data_out, 4'b0100, 8'(8'h20 + c - 1));
      end
      tick();
    end
    i_valid_in[2] = 1'b0;
    #1;
    n_cmp++;
    if (o_grant !== 4'b0100 || o_valid_out !== 1'b0) begin
      n_err++; $display("FAIL early_quiet got %b/%b exp %b/%b", o_grant, o_valid_out, 4'b0100, 1'b0);
    end
    tick();
    #1;
    n_cmp++;
    if (o_grant !== 4'b0000) begin
      n_err++; $display("FAIL early_bubble got %b exp %b", o_grant, 4'b0000);
    end
    tick();
    #1;
    n_cmp++;
    if (o_grant !== 4'b1000 || o_data_out !== 8'h30) begin
      n_err++; $display("FAIL early_next got %b/%h exp %b/%h", o_grant, o_data_out, 4'b1000, 8'h30);
    end
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    i_ready_out = 1'b1;
    i_valid_in  = 4'b1000;
    i_data_in[31:24] = 8'h30;
    tick();
    #1;
    n_cmp++;
    if (o_grant !== 4'b1000) begin
      n_err++; $display("FAIL rmid_grant got %b exp %b", o_grant, 4'b1000);
    end
    tick();
    i_data_in[31:24] = 8'h31;
    #1;
    n_cmp++;
    if (o_data_out !== 8'h31) begin
      n_err++; $display("FAIL rmid_beat2 got %h exp %h", o_data_out, 8'h31);
    end
    i_reset_n = 1'b0;
    #1;
    n_cmp++;
    if (o_grant !== 4'b0000 || o_valid_out !== 1'b0 || o_ready_in !== 4'b0000 || o_data_out !== 8'h00) begin
      n_err++; $display("FAIL rmid_clear got g=%b v=%b r=%b d=%h exp all zero",
                        o_grant, o_valid_out, o_ready_in, o_data_out);
    end
    #1;
    i_reset_n  = 1'b1;
    i_valid_in = 4'b1001;
    tick();
    #1;
    n_cmp++;
    if (o_grant !== 4'b0001) begin
      n_err++; $display("FAIL rmid_after got %b exp %b", o_grant, 4'b0001);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin arbiter that shares the single AXI-stream write port of a `fifo_axi` instance among `p_num_req` independent producers. It sits directly in front of the FIFO input. It grants one requester at a time, for a burst of at most `p_max_burst` beats, and multiplexes that requester's data/valid onto the FIFO while routing the FIFO's ready back to it. Grant state is registered, so arbitration is deterministic and starvation-free.

## Interface
- `p_width`, 8: data width per requester and of the output.
- `p_num_req`, 4: number of requesters; must be ≥ 2.
- `p_max_burst`, 4: maximum beats transferred per grant; must be ≥ 1.

- `i_clk`  in  1  single clock; all state updates on its rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_data_in`  in  `p_num_req*p_width`  requester data; requester k occupies bits `[k*p_width +: p_width]`.
- `i_valid_in`  in  `p_num_req`  per-requester valid.
- `o_ready_in`  out  `p_num_req`  per-requester ready.
- `o_data_out`  out  `p_width`  data to the FIFO write port.
- `o_valid_out`  out  1  valid to the FIFO write port.
- `i_ready_out`  in  1  ready from the FIFO (its `o_ready_in`).
- `o_grant`  out  `p_num_req`  one-hot current grant; all zero when idle.

## Operation
- **States:** `s_idle`, `s_grant`.
- **Registers:**
  - `r_sel`: granted index.
  - `r_last`: index of the last granted requester.
  - `r_count`: beats in the current grant, width `$clog2(p_max_burst+1)`.
- **Reset (asynchronous, takes effect without a clock edge):**
  - State → `s_idle`; `r_count` = 0; `r_last` = `p_num_req-1`, so requester 0 wins first.
  - `o_grant` = 0, `o_valid_out` = 0, `o_ready_in` = 0, `o_data_out` = 0.
- **`s_idle`:**
  - All outputs are driven as in reset.
  - If any `i_valid_in` bit is set, pick the first set index searching `r_last+1, r_last+2, …` modulo `p_num_req`.
  - Register it into `r_sel`, set `r_count` = 0, go to `s_grant`.
  - If no bit is set, stay in `s_idle`.
- **`s_grant`:**
  - `o_grant` = one-hot(`r_sel`).
  - `o_data_out` = data of `r_sel`; `o_valid_out` = `i_valid_in[r_sel]`.
  - `o_ready_in[r_sel]` = `i_ready_out`; every other `o_ready_in` bit = 0.
  - A handshake occurs when `o_valid_out & i_ready_out`.
  - On each handshake, `r_count` increments.
- **Release:** go to `s_idle` and set `r_last` = `r_sel` when either condition holds:
  - (a) a handshake occurs with `r_count == p_max_burst-1`; or
  - (b) no handshake occurs and `i_valid_in[r_sel]` = 0 (the producer has gone quiet).
- **Backpressure:** `i_ready_out` = 0 with valid high holds the grant indefinitely. `r_count` is unchanged and the output follows the producer's held data.
- **No ready leakage:** ungranted requesters never see ready, so none can lose a beat.
- **Fairness:** each requester waits at most `(p_num_req-1)*(p_max_burst+1)` cycles once valid, provided the FIFO drains.
- **Wrap-around:** the search pointer wraps from `p_num_req-1` to 0.
- **Multiple simultaneous requests in `s_idle`:** resolved solely by rotating priority.

## Timing
- Arbitration latency: 1 cycle from valid seen in `s_idle` to `o_grant` asserted.
- Data path in `s_grant` is combinational (mux only); there is no register stage in data or valid.
- Exactly one idle bubble cycle between consecutive grants. Sustained throughput with all requesters active and the FIFO ready is `p_max_burst/(p_max_burst+1)`.
- Release takes effect at the clock edge where the condition is evaluated; `o_grant` is 0 in the following cycle.
- A FIFO going full (`i_ready_out` = 0) mid-burst never causes a release.

## Test plan
- **Reset:** with all inputs at 1, assert `i_reset_n` = 0 between clock edges.
  - `o_grant`, `o_valid_out`, `o_ready_in` and `o_data_out` go to 0 immediately.
  - After release, the first grant goes to requester 0 when all requesters are valid.
- **Single requester:** `p_max_burst` = 4, requester 1 streams `0x10..0x15` with `i_ready_out` = 1.
  - Beats `0x10–0x13` transfer in cycles 1–4; cycle 5 is idle; `0x14–0x15` transfer in cycles 6–7.
  - `o_grant` = `4'b0010` during both bursts.
- **All four requesters continuously valid:**
  - Grant order is 0,1,2,3,0; each grant carries 4 beats followed by 1 bubble.
  - Exactly 16 beats are transferred in 20 cycles after the first grant.
- **Backpressure:** drop `i_ready_out` for 3 cycles after the 2nd beat of requester 0.
  - The grant is held and no `o_ready_in` bit is high.
  - After ready returns, beats 3–4 transfer, then release.
- **Early release:** requester 2 deasserts valid after 2 beats while requester 3 is valid.
  - Release occurs on the first non-handshake cycle with valid low.
  - The next grant goes to requester 3, one cycle later.
- **Reset mid-burst:** assert reset during requester 3's 2nd beat.
  - Outputs clear asynchronously.
  - After reset, requester 0 is granted first, even though requester 3 is still valid.
